// File: rtl/microwave_pkg.sv
// Shared types for the microwave cook timer: FSM states, BCD MM:SS time and
// its one-second decrement.
package microwave_pkg;

  typedef enum logic [1:0] {
    ST_SET    = 2'd0,
    ST_ARM    = 2'd1,
    ST_COUNT  = 2'd2,
    ST_FINISH = 2'd3
  } timer_state_t;

  typedef struct packed {
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } bcd_time_t;

  // Seconds above 59 are decremented as written, never normalized.
  function automatic bcd_time_t bcd_time_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.s1 != 4'd0) begin
      r.s1 = t.s1 - 4'd1;
    end else if (t.s10 != 4'd0) begin
      r.s10 = t.s10 - 4'd1;
      r.s1  = 4'd9;
    end else if (t.m1 != 4'd0 || t.m10 != 4'd0) begin
      if (t.m1 != 4'd0) begin
        r.m1 = t.m1 - 4'd1;
      end else begin
        r.m10 = t.m10 - 4'd1;
        r.m1  = 4'd9;
      end
      r.s10 = 4'd5;
      r.s1  = 4'd9;
    end
    return r;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Heat-time prescaler: counts enabled cycles and pulses tick on the cycle the
// count wraps, so one second is TICKS_PER_SEC enabled cycles across pauses.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 1_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)     cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (tick) cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/microwave_timer.sv
// Cook-time keypad and countdown: holds start until heat begins, counts down
// only while heating, and holds finish until the controller drops heat.
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1_000_000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        clear_btn,
  input  logic        start_btn,
  input  logic        heat,
  output logic        start,
  output logic        finish,
  output logic [15:0] disp,
  output logic        busy
);

  timer_state_t state_q, state_d;
  bcd_time_t    disp_q, disp_d;
  logic         tick;
  logic         pre_clr, pre_en;

  // Prescaler restarts from zero on every entry into COUNT.
  assign pre_clr = (state_q != ST_COUNT);
  assign pre_en  = heat && (state_q == ST_COUNT);

  sec_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_pre (
    .clk  (clk),
    .nrst (nrst),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_SET;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    case (state_q)
      ST_SET: begin
        if (clear_btn)
          disp_d = '0;
        else if (digit_valid && digit <= 4'd9)
          disp_d = {disp_q[11:0], digit};
        // A clear in the same cycle wins over start so we never arm at 0000.
        if (start_btn && !clear_btn && disp_q != '0)
          state_d = ST_ARM;
      end
      ST_ARM: begin
        if (clear_btn)
          state_d = ST_SET;
        else if (heat)
          state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (disp_q == '0)
          state_d = ST_FINISH;
        else if (clear_btn)
          disp_d = '0;
        else if (tick)
          disp_d = bcd_time_dec(disp_q);
      end
      ST_FINISH: begin
        if (!heat) begin
          state_d = ST_SET;
          disp_d  = '0;
        end
      end
      default: begin
        state_d = ST_SET;
        disp_d  = '0;
      end
    endcase
  end

  assign start  = (state_q == ST_ARM);
  assign finish = (state_q == ST_FINISH);
  assign busy   = (state_q != ST_SET);
  assign disp   = disp_q;

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer with TICKS_PER_SEC=4: a vector table for
// keypad entry and a full 00:02 cook, plus hand sequences for timing corners.
module tb_microwave_timer;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        clear_btn = 1'b0;
  logic        start_btn = 1'b0;
  logic        heat = 1'b0;
  logic        start, finish, busy;
  logic [15:0] disp;

  int tests = 0;
  int fails = 0;

  microwave_timer #(.TICKS_PER_SEC(4)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .digit_valid (digit_valid),
    .digit       (digit),
    .clear_btn   (clear_btn),
    .start_btn   (start_btn),
    .heat        (heat),
    .start       (start),
    .finish      (finish),
    .disp        (disp),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [3:0]  dg;
    logic        clr;
    logic        stb;
    logic        ht;
    logic [15:0] e_disp;
    logic        e_start;
    logic        e_finish;
    logic        e_busy;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [15:0] e_disp, input logic e_start,
                         input logic e_finish, input logic e_busy);
    chk({name, ".disp"},   disp, e_disp);
    chk({name, ".start"},  {15'd0, start},  {15'd0, e_start});
    chk({name, ".finish"}, {15'd0, finish}, {15'd0, e_finish});
    chk({name, ".busy"},   {15'd0, busy},   {15'd0, e_busy});
  endtask

  // Drive one cycle of inputs, clock it, and return #1 after the edge.
  task automatic cyc(input logic dv, input logic [3:0] dg, input logic clr,
                     input logic stb, input logic ht);
    digit_valid = dv; digit = dg; clear_btn = clr; start_btn = stb; heat = ht;
    @(posedge clk);
    #1;
    digit_valid = 1'b0; clear_btn = 1'b0; start_btn = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic vec_t mk(input logic dv, input logic [3:0] dg, input logic clr,
                              input logic stb, input logic ht, input logic [15:0] ed,
                              input logic es, input logic ef, input logic eb);
    vec_t v;
    v.dv = dv; v.dg = dg; v.clr = clr; v.stb = stb; v.ht = ht;
    v.e_disp = ed; v.e_start = es; v.e_finish = ef; v.e_busy = eb;
    return v;
  endfunction

  initial begin
    //            dv  dg     clr  stb  ht   disp      st  fin busy
    vecs[0]  = mk(1, 4'd1,  0,   0,   0,   16'h0001, 0,  0,  0);
    vecs[1]  = mk(1, 4'd3,  0,   0,   0,   16'h0013, 0,  0,  0);
    vecs[2]  = mk(1, 4'd0,  0,   0,   0,   16'h0130, 0,  0,  0);
    vecs[3]  = mk(1, 4'd7,  0,   0,   0,   16'h1307, 0,  0,  0);
    vecs[4]  = mk(1, 4'd12, 0,   0,   0,   16'h1307, 0,  0,  0);
    vecs[5]  = mk(0, 4'd0,  1,   0,   0,   16'h0000, 0,  0,  0);
    vecs[6]  = mk(1, 4'd5,  1,   0,   0,   16'h0000, 0,  0,  0);
    vecs[7]  = mk(0, 4'd0,  0,   1,   0,   16'h0000, 0,  0,  0);
    vecs[8]  = mk(0, 4'd0,  0,   0,   0,   16'h0000, 0,  0,  0);
    vecs[9]  = mk(1, 4'd2,  0,   0,   0,   16'h0002, 0,  0,  0);
    vecs[10] = mk(0, 4'd0,  0,   1,   0,   16'h0002, 1,  0,  1);
    vecs[11] = mk(1, 4'd9,  0,   1,   0,   16'h0002, 1,  0,  1);
    vecs[12] = mk(0, 4'd0,  0,   0,   0,   16'h0002, 1,  0,  1);
    vecs[13] = mk(0, 4'd0,  0,   0,   1,   16'h0002, 0,  0,  1);
    vecs[14] = mk(0, 4'd0,  0,   0,   1,   16'h0002, 0,  0,  1);
    vecs[15] = mk(0, 4'd0,  0,   0,   1,   16'h0002, 0,  0,  1);
    vecs[16] = mk(0, 4'd0,  0,   0,   1,   16'h0002, 0,  0,  1);
    vecs[17] = mk(0, 4'd0,  0,   0,   1,   16'h0001, 0,  0,  1);
    vecs[18] = mk(0, 4'd0,  0,   0,   1,   16'h0001, 0,  0,  1);
    vecs[19] = mk(0, 4'd0,  0,   0,   1,   16'h0001, 0,  0,  1);
    vecs[20] = mk(0, 4'd0,  0,   0,   1,   16'h0001, 0,  0,  1);
    vecs[21] = mk(0, 4'd0,  0,   0,   1,   16'h0000, 0,  0,  1);
    vecs[22] = mk(0, 4'd0,  0,   0,   1,   16'h0000, 0,  1,  1);
    vecs[23] = mk(0, 4'd0,  0,   0,   1,   16'h0000, 0,  1,  1);
    vecs[24] = mk(0, 4'd0,  0,   0,   0,   16'h0000, 0,  0,  0);

    #12;
    chk_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) begin
      cyc(vecs[i].dv, vecs[i].dg, vecs[i].clr, vecs[i].stb, vecs[i].ht);
      chk_all($sformatf("vec%0d", i), vecs[i].e_disp, vecs[i].e_start,
              vecs[i].e_finish, vecs[i].e_busy);
    end

    // 01:00 rolls over to 00:59 then 00:58.
    key(4'd1); key(4'd0); key(4'd0);
    chk("min_entry", disp, 16'h0100);
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("min_hold", disp, 16'h0100);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("min_roll", disp, 16'h0059);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("min_58", disp, 16'h0058);

    // Door pause after two prescale counts: two more heat cycles complete the second.
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk_all("pause", 16'h0058, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("pause_resume1", disp, 16'h0058);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("pause_resume2", disp, 16'h0057);

    // Clear during COUNT forces 0000, finish follows one cycle later.
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    chk_all("cnt_clear", 16'h0000, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk_all("cnt_clear_fin", 16'h0000, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset while in FINISH.
    #3;
    nrst = 1'b0;
    #1;
    chk_all("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    heat = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Clear in ARM returns to SET keeping the entered time.
    key(4'd1); key(4'd5);
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk_all("arm", 16'h0015, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk_all("arm_clear", 16'h0015, 1'b0, 1'b0, 1'b0);

    // Unnormalized seconds: 00:90 steps to 00:89.
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    key(4'd9); key(4'd0);
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("sec90_dec", disp, 16'h0089);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/microwave_timer.md
# microwave_timer

Cook-time keypad and countdown timer for the microwave oven: it drives the `start` and `finish` inputs of the oven door/heater controller and consumes that controller's `heat` output. The user enters a 4-digit BCD time (MM:SS), presses start, and the block holds `start` until heating begins. It then counts down only while `heat` is high and raises `finish` at zero until heating stops.

## Interface
- `TICKS_PER_SEC`, default 1_000_000: clock cycles per counted second; must be at least 2.
- `clk` input 1: system clock, all state on rising edge.
- `nrst` input 1: asynchronous active-low reset.
- `digit_valid` input 1: one-cycle keypad strobe.
- `digit` input 4: BCD key value, sampled with `digit_valid`.
- `clear_btn` input 1: one-cycle clear/cancel strobe.
- `start_btn` input 1: one-cycle start strobe.
- `heat` input 1: heater-on level from the oven controller.
- `start` output 1: start request to the controller, level.
- `finish` output 1: cook-done to the controller, level.
- `disp` output 16: BCD time `{m10,m1,s10,s1}`.
- `busy` output 1: high in any state other than SET.

## Operation
- States: SET, ARM, COUNT, FINISH. Reset to SET with `disp`=0000, prescaler 0, and `start`, `finish`, `busy` all 0.
- **SET**
  - If `digit_valid` and `digit`≤9: `disp` <= `{s10,m1,... }` shifted left one digit, so `disp` <= `{disp[11:0],digit}`.
  - A digit >9 is ignored.
  - If `clear_btn`: `disp` <= 0000. Clear has priority over a digit in the same cycle.
  - If `start_btn` and `disp`≠0000: go to ARM. If `disp`=0000, `start_btn` is ignored.
- **ARM**
  - `start`=1.
  - When `heat`=1: go to COUNT and reset the prescaler to 0.
  - `clear_btn`: return to SET with `disp` unchanged and `start` dropped. No heat has been commanded at this point.
  - Digits and `start_btn` are ignored.
- **COUNT**
  - `start`=0. The prescaler increments only while `heat`=1 and holds its value while `heat`=0 (door pause).
  - When the prescaler reaches `TICKS_PER_SEC-1` with `heat`=1: it wraps to 0 and `disp` is decremented.
  - Decrement rules:
    - If s1>0: s1--.
    - Else if s10>0: s10--, s1=9.
    - Else if minutes>0: decrement the 2-digit minutes BCD and set seconds to 59.
  - Entered seconds above 59 (e.g. 00:99) count down as written; they are not normalized.
  - `clear_btn` forces `disp` <= 0000.
  - When `disp`=0000: go to FINISH. This covers both the decrement and the clear case.
- **FINISH**
  - `finish`=1.
  - When `heat`=0: go to SET with `disp`=0000.
- `digit_valid`, `start_btn` and `clear_btn` in states not listed above are ignored.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Key strobe at edge n: `disp` reflects it after edge n.
- `start_btn` at edge n: `start`=1 from n until the edge where `heat`=1 is sampled. The controller sees `start` in CLOSED even if the door was open at press time.
- Countdown period: exactly `TICKS_PER_SEC` cycles of `heat`=1 per second, counted across pauses.
- Last decrement to 0000 at edge n: FINISH entered at n+1, so `finish`=1 one cycle after `disp` shows 0000.
- `finish` stays high while `heat`=1. The controller sees it in COOK; if the door opens, it drops `heat` and `finish` clears.
- Reset mid-operation: immediate return to SET/0000 with `start` and `finish` low.

## Structure
- Package `microwave_pkg`:
  - state enum `timer_state_t`.
  - BCD time typedef `bcd_time_t` (4×4 bits).
  - function `bcd_time_dec`.
- Sub-module `sec_prescaler`:
  - Parameter `TICKS_PER_SEC`.
  - Inputs `clk`, `nrst`, `clr`, `en`.
  - Output `tick`, a one-cycle pulse when the count wraps.
  - Counter width `$clog2(TICKS_PER_SEC)`.

## Test plan
(All scenarios use `TICKS_PER_SEC`=4.)
- Keys 1,3,0 then 7: `disp` reads 0130, then 1307; `digit`=12 leaves it unchanged; clear gives 0000.
- `disp`=0000 with `start_btn`: stays in SET, `start`=0, `busy`=0.
- `disp`=0002, `start_btn`, `heat` raised 3 cycles later:
  - `start` high for exactly those 3 cycles.
  - `disp` goes 0001 after 4 heat cycles, then 0000 after 8.
  - `finish` is asserted next cycle.
  - Dropping `heat` returns to SET.
- `disp`=0100 counting: `disp` steps 0100 → 0059 → 0058.
- Pause: `heat` low for 10 cycles after 2 ticks of prescale; the next decrement occurs 2 heat cycles after `heat` returns.
- `clear_btn` in COUNT: `disp`=0000 and `finish`=1 next cycle. `nrst` pulsed in FINISH: all outputs 0 and `disp`=0000 immediately.
